// File: rtl/itlb_fa.sv
// ============================================================================
// Module  : itlb_fa
// Brief   : Fully associative instruction TLB. Same-cycle translation on hit;
//           on miss, stalls fetch, issues one PTW walk and installs the result.
//           Optional hit/miss counters are enabled by ITLB_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module itlb_fa #(
  parameter int VA_WIDTH          = 32,
  parameter int PC_BITS           = 20,
  parameter int PAGE_OFFSET_WIDTH = 12,
  parameter int VPN_WIDTH         = VA_WIDTH - PAGE_OFFSET_WIDTH,
  parameter int PPN_WIDTH         = PC_BITS - PAGE_OFFSET_WIDTH,
  parameter int ENTRIES           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 F_va_valid,
  input  logic [VA_WIDTH-1:0]  F_va,
  output logic [PC_BITS-1:0]   F_pa,
  output logic                 F_tlb_hit,
  output logic                 F_tlb_stall,
  input  logic                 Itlb_flush,
  output logic                 Itlb_pa_request,
  output logic [VPN_WIDTH-1:0] Itlb_va,
  input  logic                 F_ptw_valid,
  input  logic [PPN_WIDTH-1:0] F_ptw_pa
`ifdef ITLB_PERF_CNT_EN
  ,
  output logic [31:0]          Itlb_hit_cnt,
  output logic [31:0]          Itlb_miss_cnt
`endif
);

  localparam int C_IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ENTRIES-1:0]   r_valid;
  logic [VPN_WIDTH-1:0] r_tag [ENTRIES];
  logic [PPN_WIDTH-1:0] r_ppn [ENTRIES];
  logic [C_IDX_W-1:0]   r_rr;
  logic [VPN_WIDTH-1:0] r_vpn;
  logic                 r_req;

  logic [VPN_WIDTH-1:0] w_va_vpn;
  logic [ENTRIES-1:0]   w_match;
  logic                 w_hit_any;
  logic [C_IDX_W-1:0]   w_hit_idx;
  logic                 w_all_valid;
  logic [C_IDX_W-1:0]   w_free_idx;
  logic [C_IDX_W-1:0]   w_victim;
  logic                 w_start;
  logic                 w_fill;

  assign w_va_vpn = F_va[VA_WIDTH-1:PAGE_OFFSET_WIDTH];

  generate
    for (genvar g = 0; g < ENTRIES; g++) begin : g_match
      assign w_match[g] = r_valid[g] && (r_tag[g] == w_va_vpn);
    end
  endgenerate

  // Descending scans so the lowest matching / free index is the one kept.
  always_comb begin
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i])  w_hit_idx  = C_IDX_W'(i);
      if (!r_valid[i]) w_free_idx = C_IDX_W'(i);
    end
  end

  assign w_hit_any   = |w_match;
  assign w_all_valid = &r_valid;
  assign w_victim    = w_all_valid ? r_rr : w_free_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fill      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (F_va_valid && !w_hit_any && !Itlb_flush) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_state_nxt = Itlb_flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        // A flush racing the response drops the fill; the walk is then complete.
        if (Itlb_flush) begin
          w_state_nxt = F_ptw_valid ? S_IDLE : S_DRAIN;
        end else if (F_ptw_valid) begin
          w_fill      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (F_ptw_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_vpn   <= '0;
      r_valid <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_start;
      if (w_start) r_vpn <= w_va_vpn;
      if (Itlb_flush) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_victim] <= 1'b1;
      end
      if (w_fill && w_all_valid) r_rr <= r_rr + 1'b1;
    end
  end

  // Tag/PPN storage is qualified by r_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_victim] <= r_vpn;
      r_ppn[w_victim] <= F_ptw_pa;
    end
  end

  assign F_tlb_hit       = F_va_valid && w_hit_any && (r_state == S_IDLE);
  assign F_pa            = F_tlb_hit ? {r_ppn[w_hit_idx], F_va[PAGE_OFFSET_WIDTH-1:0]}
                                     : '0;
  assign F_tlb_stall     = (r_state != S_IDLE) || (F_va_valid && !w_hit_any);
  assign Itlb_pa_request = r_req;
  assign Itlb_va         = r_vpn;

`ifdef ITLB_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (F_tlb_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_start)   r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign Itlb_hit_cnt  = r_hit_cnt;
  assign Itlb_miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire
